instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: instr_in  input  16  instruction word; opcode in [15:13], Rx in [12:10], Ry in [9:7].
REQ-004 SHALL have port: instr_valid  input  1  upstream holds a valid instr_in this cycle.
REQ-005 SHALL have port: instr_ready  output  1  queue accepts a word this cycle.
REQ-006 SHALL have port: run  input  1  level enable for starting new instructions.
REQ-007 SHALL have port: clear_counter  input  1  end-of-instruction acknowledge from control unit.
REQ-008 SHALL have port: instruction  output  16  instruction register (IR) to the control unit.
REQ-009 SHALL have port: current_state  output  2  step counter to the control unit.
REQ-010 SHALL have port: busy  output  1  an instruction is in execution.
REQ-011 SHALL have port: done  output  1  one-cycle pulse per retired instruction.
REQ-012 SHALL have port: fifo_count  output  3  queue occupancy, 0..4.
REQ-013 SHALL have port: timeout_error  output  1  sticky watchdog flag.
REQ-014 SHALL have parameter: DEPTH, default 4, queue depth (power of two).
REQ-015 SHALL have parameter: ACK_TIMEOUT, default 7, max cycles in step 11 awaiting clear_counter.

Function
REQ-016 SHALL contain a DEPTH-entry FIFO with read and write pointers; wrap-around is modulo DEPTH.
REQ-017 SHALL drive instr_ready = (fifo_count != DEPTH); it SHALL NOT depend on a same-cycle pop.
REQ-018 SHALL push instr_in when instr_valid && instr_ready; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-019 SHALL use FSM states IDLE and EXEC.
REQ-020 IDLE: when run && fifo_count != 0, SHALL pop the head into instruction, set current_state to 00, and enter EXEC on the next edge.
REQ-021 EXEC: current_state SHALL advance 00->01->10->11, one step per cycle, and SHALL hold at 11.
REQ-022 In EXEC at 11 with clear_counter=1: SHALL pulse done for one cycle and set current_state to 00. If run && fifo_count != 0, SHALL pop the next word into instruction in the same cycle and remain in EXEC (back-to-back operation). Otherwise SHALL go to IDLE.
REQ-023 clear_counter SHALL be ignored outside EXEC step 11.
REQ-024 SHALL count cycles spent at 11. If ACK_TIMEOUT cycles elapse with no clear_counter, SHALL set timeout_error, go to IDLE with current_state 00, and SHALL NOT pulse done.
REQ-025 A push into an empty FIFO SHALL NOT be poppable in the same cycle; the first pop occurs the cycle after.
REQ-026 Deasserting run SHALL NOT abort an executing instruction; it SHALL only block new pops.
REQ-027 busy SHALL equal (state == EXEC).
REQ-028 instruction SHALL hold its value between pops.

Reset
REQ-029 On reset: state=IDLE, current_state=00, instruction=0, done=0, busy=0, FIFO pointers=0, fifo_count=0, timeout_error=0, watchdog=0.
REQ-030 Reset SHALL take effect mid-instruction without a done pulse and SHALL discard queued words.
REQ-031 timeout_error SHALL clear only on reset.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, the step encodings (00..11), and the opcode constants shared with the control unit.
REQ-033 The FIFO SHALL be a sub-module, instr_fifo (push, pop, data, count, full, empty).

Verification
REQ-034 Reset mid-EXEC at step 10 -> next cycle current_state=00, busy=0, fifo_count=0, no done.
REQ-035 Push 0xA400 with run=1 and clear_counter asserted at step 11 -> steps 00,01,10,11; done=1 for exactly one cycle; then IDLE.
REQ-036 Push 4 words with run=0 -> fifo_count=4, instr_ready=0; a 5th word is held off; ordering is FIFO on run=1.
REQ-037 Two queued words with clear_counter at step 11 -> second word in instruction the same edge done pulses; current_state returns to 00 with no IDLE cycle.
REQ-038 Never assert clear_counter -> after 7 cycles at 11, timeout_error=1, state IDLE, done never pulsed.
REQ-039 Push and pop in the same cycle with fifo_count=2 -> fifo_count stays 2; pointer wrap past entry 3 preserves order.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared FSM, step and opcode encodings
package instr_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_t;

  localparam logic [1:0] STEP_00 = 2'b00;
  localparam logic [1:0] STEP_01 = 2'b01;
  localparam logic [1:0] STEP_10 = 2'b10;
  localparam logic [1:0] STEP_11 = 2'b11;

  // Opcodes as decoded by the control unit from instruction[15:13]
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  function automatic logic [1:0] next_step(input logic [1:0] s);
    return (s == STEP_11) ? STEP_11 : s + 2'd1;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction feed and control-unit handshake bundle
interface instr_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   instr_in;
  logic          instr_valid;
  logic          instr_ready;
  logic          run;
  logic          clear_counter;
  logic [15:0]   instruction;
  logic [1:0]    current_state;
  logic          busy;
  logic          done;
  logic [CW-1:0] fifo_count;
  logic          timeout_error;

  modport master (
    output instr_in, instr_valid, run, clear_counter,
    input  instr_ready, instruction, current_state, busy, done, fifo_count, timeout_error
  );

  modport slave (
    input  instr_in, instr_valid, run, clear_counter,
    output instr_ready, instruction, current_state, busy, done, fifo_count, timeout_error
  );

endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - power-of-two instruction queue with wrapping pointers
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign data    = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers are exactly AW bits wide, so natural overflow gives the modulo-DEPTH wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - queues instruction words and steps each through a 4-phase execution
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 7
) (
  input  logic              clock,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  seq_state_t     state;
  logic [1:0]     step;
  logic [15:0]    ir;
  logic           done_q;
  logic           timeout_q;
  logic [WW-1:0]  wdog;

  logic [15:0]    fifo_data;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           start;
  logic           ack;
  logic           pop;

  assign start = bus.run && !fifo_empty;
  assign ack   = (state == EXEC) && (step == STEP_11) && bus.clear_counter;
  assign pop   = start && ((state == IDLE) || ack);

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.instr_valid),
    .pop   (pop),
    .wdata (bus.instr_in),
    .data  (fifo_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      step      <= STEP_00;
      ir        <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wdog      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ir    <= fifo_data;
            step  <= STEP_00;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (step != STEP_11) begin
            step <= next_step(step);
            wdog <= '0;
          end else if (bus.clear_counter) begin
            done_q <= 1'b1;
            step   <= STEP_00;
            wdog   <= '0;
            // Back-to-back: the next word loads on the same edge that retires this one
            if (start) ir    <= fifo_data;
            else       state <= IDLE;
          end else if (wdog == WW'(ACK_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
            step      <= STEP_00;
            wdog      <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.instr_ready   = !fifo_full;
  assign bus.instruction   = ir;
  assign bus.current_state = step;
  assign bus.busy          = (state == EXEC);
  assign bus.done          = done_q;
  assign bus.fifo_count    = fifo_count;
  assign bus.timeout_error = timeout_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   done_cnt = 0;

  instr_sequencer_if #(.DEPTH(4)) bus ();

  instr_sequencer #(.DEPTH(4), .ACK_TIMEOUT(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.done === 1'b1) done_cnt++;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    bus.instr_in = '0; bus.instr_valid = 0; bus.run = 0; bus.clear_counter = 0;
    reset = 1;
    repeat (2) tick;
    total++; if (bus.current_state !== 2'b00) $display("FAIL reset_step got %b want 00", bus.current_state); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
    total++; if (bus.fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.fifo_count); else passed++;
    total++; if (bus.instruction !== 16'h0000) $display("FAIL reset_ir got %h want 0000", bus.instruction); else passed++;
    total++; if (bus.timeout_error !== 1'b0) $display("FAIL reset_timeout got %b want 0", bus.timeout_error); else passed++;
    total++; if (bus.instr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.instr_ready); else passed++;
    reset = 0;
    tick;
  endtask

  task automatic test_single;
    int d0;
    d0 = done_cnt;
    bus.instr_in = 16'hA400; bus.instr_valid = 1; bus.run = 1;
    tick;
    total++; if (bus.busy !== 1'b0) $display("FAIL push_no_same_cycle_pop busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.fifo_count !== 3'd1) $display("FAIL single_push_count got %0d want 1", bus.fifo_count); else passed++;
    bus.instr_valid = 0;
    tick;
    total++; if (bus.busy !== 1'b1) $display("FAIL single_busy got %b want 1", bus.busy); else passed++;
    total++; if (bus.instruction !== 16'hA400) $display("FAIL single_ir got %h want a400", bus.instruction); else passed++;
    total++; if (bus.current_state !== 2'b00) $display("FAIL single_step0 got %b want 00", bus.current_state); else passed++;
    for (int s = 1; s < 4; s++) begin
      tick;
      total++; if (bus.current_state !== 2'(s)) $display("FAIL single_step got %b want %b", bus.current_state, 2'(s)); else passed++;
    end
    bus.clear_counter = 1;
    tick;
    total++; if (bus.done !== 1'b1) $display("FAIL single_done got %b want 1", bus.done); else passed++;
    total++; if (bus.current_state !== 2'b00) $display("FAIL single_retire_step got %b want 00", bus.current_state); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL single_idle busy got %b want 0", bus.busy); else passed++;
    bus.clear_counter = 0;
    tick;
    total++; if (bus.done !== 1'b0) $display("FAIL single_done_width got %b want 0", bus.done); else passed++;
    total++; if (done_cnt - d0 !== 1) $display("FAIL single_done_count got %0d want 1", done_cnt - d0); else passed++;
    bus.run = 0;
  endtask

  task automatic test_full_back_to_back;
    logic [15:0] w [4];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
    bus.run = 0;
    for (int i = 0; i < 4; i++) begin
      bus.instr_in = w[i]; bus.instr_valid = 1;
      tick;
    end
    total++; if (bus.fifo_count !== 3'd4) $display("FAIL full_count got %0d want 4", bus.fifo_count); else passed++;
    total++; if (bus.instr_ready !== 1'b0) $display("FAIL full_ready got %b want 0", bus.instr_ready); else passed++;
    bus.instr_in = 16'h5555;
    repeat (2) tick;
    total++; if (bus.fifo_count !== 3'd4) $display("FAIL full_holdoff got %0d want 4", bus.fifo_count); else passed++;
    bus.instr_valid = 0; bus.run = 1;
    tick;
    total++; if (bus.instruction !== w[0]) $display("FAIL order_0 got %h want %h", bus.instruction, w[0]); else passed++;
    for (int i = 1; i < 4; i++) begin
      repeat (3) tick;
      bus.clear_counter = 1;
      tick;
      total++; if (bus.instruction !== w[i]) $display("FAIL order_b2b got %h want %h", bus.instruction, w[i]); else passed++;
      total++; if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.current_state !== 2'b00)
        $display("FAIL b2b_flags got done=%b busy=%b step=%b want 1 1 00", bus.done, bus.busy, bus.current_state);
      else passed++;
      bus.clear_counter = 0;
    end
    repeat (3) tick;
    bus.clear_counter = 1;
    tick;
    bus.clear_counter = 0;
    total++; if (bus.busy !== 1'b0 || bus.fifo_count !== 3'd0) $display("FAIL full_drain got busy=%b count=%0d want 0 0", bus.busy, bus.fifo_count); else passed++;
    total++; if (bus.instruction !== w[3]) $display("FAIL ir_hold got %h want %h", bus.instruction, w[3]); else passed++;
    bus.run = 0;
    tick;
  endtask

  task automatic test_timeout;
    int d0;
    d0 = done_cnt;
    bus.instr_in = 16'h8E00; bus.instr_valid = 1; bus.run = 1;
    tick;
    bus.instr_valid = 0;
    tick;
    bus.run = 0; bus.clear_counter = 1;
    tick;
    total++; if (bus.current_state !== 2'b01 || bus.done !== 1'b0) $display("FAIL early_clear got step=%b done=%b want 01 0", bus.current_state, bus.done); else passed++;
    bus.clear_counter = 0;
    repeat (2) tick;
    repeat (6) tick;
    total++; if (bus.current_state !== 2'b11 || bus.timeout_error !== 1'b0) $display("FAIL wdog_early got step=%b to=%b want 11 0", bus.current_state, bus.timeout_error); else passed++;
    tick;
    total++; if (bus.timeout_error !== 1'b1) $display("FAIL timeout_set got %b want 1", bus.timeout_error); else passed++;
    total++; if (bus.busy !== 1'b0 || bus.current_state !== 2'b00) $display("FAIL timeout_idle got busy=%b step=%b want 0 00", bus.busy, bus.current_state); else passed++;
    repeat (3) tick;
    total++; if (bus.timeout_error !== 1'b1) $display("FAIL timeout_sticky got %b want 1", bus.timeout_error); else passed++;
    total++; if (done_cnt !== d0) $display("FAIL timeout_no_done got %0d want %0d", done_cnt, d0); else passed++;
  endtask

  task automatic test_wrap;
    logic [15:0] e [3];
    e[0] = 16'h2003; e[1] = 16'h2004; e[2] = 16'h2005;
    bus.run = 0;
    bus.instr_in = 16'h2001; bus.instr_valid = 1; tick;
    bus.instr_in = 16'h2002; tick;
    bus.instr_in = 16'h2003; bus.run = 1; tick;
    total++; if (bus.fifo_count !== 3'd2) $display("FAIL push_pop_count got %0d want 2", bus.fifo_count); else passed++;
    total++; if (bus.instruction !== 16'h2001) $display("FAIL push_pop_ir got %h want 2001", bus.instruction); else passed++;
    bus.instr_in = 16'h2004; tick;
    bus.instr_in = 16'h2005; tick;
    total++; if (bus.fifo_count !== 3'd4) $display("FAIL wrap_count got %0d want 4", bus.fifo_count); else passed++;
    bus.instr_valid = 0; tick;
    bus.clear_counter = 1; tick;
    total++; if (bus.instruction !== 16'h2002) $display("FAIL wrap_order got %h want 2002", bus.instruction); else passed++;
    bus.clear_counter = 0;
    for (int i = 0; i < 3; i++) begin
      repeat (3) tick;
      bus.clear_counter = 1;
      tick;
      total++; if (bus.instruction !== e[i]) $display("FAIL wrap_order got %h want %h", bus.instruction, e[i]); else passed++;
      bus.clear_counter = 0;
    end
    bus.run = 0;
    repeat (4) tick;
    bus.clear_counter = 1; tick; bus.clear_counter = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    int d0;
    bus.run = 0;
    for (int i = 0; i < 3; i++) begin
      bus.instr_in = 16'h6000 + 16'(i); bus.instr_valid = 1;
      tick;
    end
    bus.instr_valid = 0; bus.run = 1;
    tick;
    repeat (2) tick;
    total++; if (bus.current_state !== 2'b10) $display("FAIL mid_step got %b want 10", bus.current_state); else passed++;
    d0 = done_cnt;
    reset = 1;
    tick;
    total++; if (bus.current_state !== 2'b00 || bus.busy !== 1'b0) $display("FAIL mid_reset got step=%b busy=%b want 00 0", bus.current_state, bus.busy); else passed++;
    total++; if (bus.fifo_count !== 3'd0) $display("FAIL mid_reset_count got %0d want 0", bus.fifo_count); else passed++;
    total++; if (bus.timeout_error !== 1'b0 || bus.instruction !== 16'h0000) $display("FAIL mid_reset_regs got to=%b ir=%h want 0 0000", bus.timeout_error, bus.instruction); else passed++;
    reset = 0; bus.run = 0;
    tick;
    total++; if (done_cnt !== d0) $display("FAIL mid_reset_no_done got %0d want %0d", done_cnt, d0); else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_full_back_to_back;
    test_timeout;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
